pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage core (IF, ID, EX, MEM, WB). It collects stall requests, exceptions and branch-likely slot-kill requests, and drives the per-register stall/flush/clrslot controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Exception flushes are deferred while IF has an uncancellable bus transaction in flight. Branch-likely slot clears are held pending until IF/ID can accept them.

Parameters:
ADDR_W, 32, width of redirect PC.
PERF_W, 32, width of performance counters (used only with optional feature).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
req_if  in  1  IF stall request (icache miss / bus wait).
req_id  in  1  ID stall request (load-use / operand hazard).
req_ex  in  1  EX stall request (multi-cycle mul/div busy).
req_mem  in  1  MEM stall request (dcache / bus wait).
if_busy  in  1  IF bus transaction outstanding, cannot be cancelled.
exc_req  in  1  exception taken in MEM this cycle.
exc_pc  in  ADDR_W  exception handler target.
id_likely_nt  in  1  branch-likely in ID not taken; delay slot must be killed (1-cycle pulse).
stall  out  5  per-register hold; bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB.
flush  out  5  per-register clear to bubble, same bit mapping.
clrslot  out  1  IF/ID delay-slot clear.
redirect  out  1  PC load strobe.
redirect_pc  out  ADDR_W  PC load target.
perf_stall_cnt  out  PERF_W  cycles with stall[0]=1.
perf_flush_cnt  out  PERF_W  exception flushes issued.

Behaviour:
- State: RUN, EXC_WAIT. Registers: state, exc_pc_q (ADDR_W), slot_pend. Reset: RUN, exc_pc_q=0, slot_pend=0.
- All outputs combinational from state and inputs. While rst=1: all outputs 0.
- Stall source index s: deepest requester wins. req_mem→4, req_ex→3, req_id→2, req_if→1, none→0.
- Stall with s>0: stall[j]=1 for j<s. flush[s]=1 to insert a bubble, except s=4, where MEM/WB receives bubble flush[4]=1. stall[j]=0 for j>=s.
- RUN, exc_req=1, if_busy=0: flush=5'b11110, stall=0, redirect=1, redirect_pc=exc_pc in the same cycle. Stall requests are ignored and slot_pend is cleared. State stays RUN.
- RUN, exc_req=1, if_busy=1: latch exc_pc_q=exc_pc and go to EXC_WAIT. This cycle: stall=5'b11111, flush=0, redirect=0.
- EXC_WAIT, if_busy=1: stall=5'b11111, flush=0. exc_req and id_likely_nt are ignored.
- EXC_WAIT, if_busy=0: flush=5'b11110, redirect=1, redirect_pc=exc_pc_q, slot_pend cleared, go to RUN. Exactly one flush cycle per exception.
- Flush has priority over stall on every register.
- clrslot = (id_likely_nt | slot_pend) & ~stall[1] & state==RUN & ~exc_req.
- slot_pend set when (id_likely_nt | slot_pend) & stall[1] in RUN. Cleared when clrslot is issued or on exception flush.
- A simultaneous req_* and id_likely_nt keeps the kill pending across any number of stall cycles.
- redirect_pc=0 when redirect=0.
- Asynchronous reset mid-EXC_WAIT returns to RUN. The latched exception is discarded.

Optional Feature:
PIPE_CTRL_PERF_EN: when defined, two saturating PERF_W counters are built, both reset to 0.
- perf_stall_cnt increments each cycle stall[0]=1.
- perf_flush_cnt increments each redirect cycle.
When undefined, both ports are tied to 0 and no counter flops are synthesized.

Test Plan:
1. req_ex=1 for 3 cycles, no others → stall=5'b00111 and flush=5'b01000 for exactly 3 cycles, then stall=0, flush=0.
2. req_if=1 and req_mem=1 together → stall=5'b01111, flush=5'b10000 (deepest wins).
3. exc_req=1, exc_pc=0xBFC00380, if_busy=0 → same cycle: flush=5'b11110, redirect=1, redirect_pc=0xBFC00380, state RUN.
4. exc_req=1, exc_pc=0x80000180, if_busy=1 for 4 cycles → 4 cycles of stall=5'b11111 with redirect=0; 5th cycle: flush=5'b11110, redirect=1, redirect_pc=0x80000180; next cycle outputs idle.
5. id_likely_nt pulse with req_id=1 for 2 cycles → clrslot=0 during stall, clrslot=1 in the first cycle req_id=0, then 0.
6. rst asserted during EXC_WAIT then released, if_busy=0 → no redirect issued, all outputs 0. With PIPE_CTRL_PERF_EN, counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline stall/flush/slot-kill controller (optional PIPE_CTRL_PERF_EN counters)
module pipe_hazard_ctrl #(
  parameter int ADDR_W = 32,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_if,
  input  logic              req_id,
  input  logic              req_ex,
  input  logic              req_mem,
  input  logic              if_busy,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_pc,
  input  logic              id_likely_nt,
  output logic [4:0]        stall,
  output logic [4:0]        flush,
  output logic              clrslot,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  typedef enum logic {
    RUN      = 1'b0,
    EXC_WAIT = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] exc_pc_q;
  logic              slot_pend;
  logic              kill_want;

  assign kill_want = id_likely_nt | slot_pend;

  // Output decode: exception handling first, otherwise deepest stall requester sets the hold/bubble boundary
  always_comb begin
    stall       = 5'b00000;
    flush       = 5'b00000;
    clrslot     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    if (rst) begin
      stall = 5'b00000;
    end else if (state == EXC_WAIT) begin
      if (if_busy) begin
        stall = 5'b11111;
      end else begin
        flush       = 5'b11110;
        redirect    = 1'b1;
        redirect_pc = exc_pc_q;
      end
    end else if (exc_req) begin
      if (if_busy) begin
        stall = 5'b11111;
      end else begin
        flush       = 5'b11110;
        redirect    = 1'b1;
        redirect_pc = exc_pc;
      end
    end else begin
      if (req_mem) begin
        stall = 5'b01111;
        flush = 5'b10000;
      end else if (req_ex) begin
        stall = 5'b00111;
        flush = 5'b01000;
      end else if (req_id) begin
        stall = 5'b00011;
        flush = 5'b00100;
      end else if (req_if) begin
        stall = 5'b00001;
        flush = 5'b00010;
      end
      clrslot = kill_want & ~stall[1];
    end
  end

  // Exception deferral FSM plus the pending delay-slot kill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      exc_pc_q  <= '0;
      slot_pend <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (exc_req) begin
            // Either flushed now or flushed when the bus frees; the kill is moot either way
            slot_pend <= 1'b0;
            if (if_busy) begin
              exc_pc_q <= exc_pc;
              state    <= EXC_WAIT;
            end
          end else if (kill_want & stall[1]) begin
            slot_pend <= 1'b1;
          end else if (clrslot) begin
            slot_pend <= 1'b0;
          end
        end
        EXC_WAIT: begin
          if (!if_busy) begin
            slot_pend <= 1'b0;
            state     <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;

  // Saturating event counters for front-end stall cycles and exception redirects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall[0] && (stall_cnt_q != {PERF_W{1'b1}})) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect && (flush_cnt_q != {PERF_W{1'b1}})) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign perf_stall_cnt = rst ? '0 : stall_cnt_q;
  assign perf_flush_cnt = rst ? '0 : flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
